// File: rtl/uart_tx.sv
// uart_tx: 8N1 serial transmitter. It accepts one byte per tx_req while idle and has no buffering beyond that byte.
// Latency: uart_txd and tx_busy change one cycle after the accepting edge. A frame lasts 10*CLKS_PER_BIT cycles.
// Backpressure: while tx_busy is high, tx_req is ignored and the byte is silently dropped. Software must poll tx_busy before writing.
module uart_tx #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_req,
  input  logic [7:0] tx_data,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       uart_txd
);

  // CLKS_PER_BIT of 2 or more always gives a counter width of at least 1.
  localparam int              BAUD_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t            state_q;
  logic [BAUD_W-1:0] baud_cnt_q;
  logic [BAUD_W-1:0] baud_cnt_d;
  logic [2:0]        bit_idx_q;
  logic [7:0]        shift_q;
  logic              txd_q;
  logic              busy_q;
  logic              done_q;
  logic              baud_tc;

  // The last cycle of the current serial bit.
  assign baud_tc = (baud_cnt_q == BAUD_LAST);

  // The baud counter stays at 0 while idle, so the first frame cycle starts a full bit period.
  always_comb begin
    baud_cnt_d = '0;
    if (state_q != IDLE && !baud_tc) begin
      baud_cnt_d = baud_cnt_q + BAUD_W'(1);
    end
  end

  // Frame sequencer. All outputs are registered here, so no path runs from an input to an output.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      baud_cnt_q <= '0;
      bit_idx_q  <= 3'd0;
      shift_q    <= 8'h00;
      txd_q      <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q     <= 1'b0;
      baud_cnt_q <= baud_cnt_d;
      case (state_q)
        IDLE: begin
          if (tx_req) begin
            shift_q <= tx_data;
            state_q <= START;
            txd_q   <= 1'b0;
            busy_q  <= 1'b1;
          end
        end
        START: begin
          if (baud_tc) begin
            state_q   <= DATA;
            bit_idx_q <= 3'd0;
            txd_q     <= shift_q[0];
          end
        end
        DATA: begin
          if (baud_tc) begin
            shift_q   <= {1'b0, shift_q[7:1]};
            bit_idx_q <= bit_idx_q + 3'd1;
            if (bit_idx_q == 3'd7) begin
              state_q <= STOP;
              txd_q   <= 1'b1;
            end else begin
              txd_q   <= shift_q[1];
            end
          end
        end
        STOP: begin
          if (baud_tc) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            txd_q   <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          txd_q   <= 1'b1;
        end
      endcase
    end
  end

  assign tx_busy  = busy_q;
  assign tx_done  = done_q;
  assign uart_txd = txd_q;

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed checks of uart_tx with CLKS_PER_BIT = 4.
// Latency: inputs are driven and outputs are sampled on the falling edge.
// Backpressure: covers a request while busy, a back-to-back request and a reset in mid-frame.
module tb_uart_tx;

  localparam int CPB = 4;
  localparam int MAXC = 200;

  logic       clk;
  logic       rst;
  logic       tx_req;
  logic [7:0] tx_data;
  logic       tx_busy;
  logic       tx_done;
  logic       uart_txd;

  int checks;
  int failures;

  logic line_q [0:MAXC-1];

  uart_tx #(.CLKS_PER_BIT(CPB)) dut (
    .clk      (clk),
    .rst      (rst),
    .tx_req   (tx_req),
    .tx_data  (tx_data),
    .tx_busy  (tx_busy),
    .tx_done  (tx_done),
    .uart_txd (uart_txd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Pulses tx_req for one cycle. Returns at the first frame cycle and checks that the frame has started.
  task automatic start(input string tag, input logic [7:0] d);
    tx_req  = 1'b1;
    tx_data = d;
    @(negedge clk);
    tx_req  = 1'b0;
    check({tag, "_accept_busy"}, 32'(tx_busy), 32'd1);
    check({tag, "_accept_txd"}, 32'(uart_txd), 32'd0);
  endtask

  // Records the line while busy. It can inject a request, a data change or a reset at a given frame cycle.
  // It returns in the first non-busy cycle.
  task automatic run_frame(input int req_at, input logic [7:0] req_dat,
                           input int dat_at, input logic [7:0] dat_val,
                           input int rst_at,
                           output logic [9:0] bits, output int busy_len,
                           output int low_cnt, output int first_high, output int glitches);
    int c;
    c = 0;
    low_cnt = 0;
    first_high = -1;
    glitches = 0;
    bits = '0;
    while (c < MAXC) begin
      tx_req = 1'b0;
      rst    = 1'b0;
      if (!tx_busy) break;
      line_q[c] = uart_txd;
      if (!uart_txd) low_cnt++;
      if (uart_txd && first_high < 0) first_high = c;
      if (c == req_at) begin tx_req = 1'b1; tx_data = req_dat; end
      if (c == dat_at) tx_data = dat_val;
      if (c == rst_at) rst = 1'b1;
      c++;
      @(negedge clk);
    end
    if (c >= MAXC) check("frame_timeout", 32'(c), 32'd0);
    busy_len = c;
    for (int i = 0; i < 10; i++) begin
      if (i * CPB + 2 < c) bits[i] = line_q[i * CPB + 2];
    end
    for (int i = 0; i < c; i++) begin
      if (line_q[i] !== line_q[(i / CPB) * CPB]) glitches++;
    end
  endtask

  // Runs an undisturbed frame and checks its bits, its length and the tx_done pulse that follows.
  task automatic plain_frame(input string tag, input logic [7:0] d,
                             output int low_cnt, output int first_high);
    logic [9:0] bits;
    int blen, gl;
    start(tag, d);
    run_frame(-1, 8'h00, -1, 8'h00, -1, bits, blen, low_cnt, first_high, gl);
    check({tag, "_bits"}, 32'(bits), 32'({1'b1, d, 1'b0}));
    check({tag, "_busy_len"}, 32'(blen), 32'd40);
    check({tag, "_hold"}, 32'(gl), 32'd0);
    check({tag, "_done"}, 32'(tx_done), 32'd1);
  endtask

  initial begin
    logic [9:0] bits;
    int blen, lc, fh, gl, extra;
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    tx_req   = 1'b0;
    tx_data  = 8'h00;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_txd", 32'(uart_txd), 32'd1);
    check("rst_busy", 32'(tx_busy), 32'd0);
    check("rst_done", 32'(tx_done), 32'd0);
    @(negedge clk);

    // Single byte 0x55: centre samples alternate 0,1,...,1. Busy lasts 40 cycles and tx_done follows in cycle 41.
    plain_frame("b55", 8'h55, lc, fh);
    @(negedge clk);
    check("b55_done_once", 32'(tx_done), 32'd0);
    check("b55_idle_txd", 32'(uart_txd), 32'd1);

    // Data extremes.
    plain_frame("b00", 8'h00, lc, fh);
    check("b00_low_cnt", 32'(lc), 32'd36);
    check("b00_first_high", 32'(fh), 32'd36);
    @(negedge clk);
    plain_frame("bff", 8'hFF, lc, fh);
    check("bff_low_cnt", 32'(lc), 32'd4);
    check("bff_first_high", 32'(fh), 32'd4);
    @(negedge clk);

    // A request during the frame is ignored, and no second frame follows.
    start("ba5", 8'hA5);
    run_frame(10, 8'h3C, -1, 8'h00, -1, bits, blen, lc, fh, gl);
    check("ba5_bits", 32'(bits), 32'({1'b1, 8'hA5, 1'b0}));
    check("ba5_busy_len", 32'(blen), 32'd40);
    extra = 0;
    repeat (45) begin
      @(negedge clk);
      if (tx_busy || !uart_txd) extra++;
    end
    check("ba5_no_second", 32'(extra), 32'd0);

    // Back-to-back: the second request arrives in the tx_done cycle, leaving a one-cycle idle gap.
    plain_frame("b12", 8'h12, lc, fh);
    check("b2b_gap_busy", 32'(tx_busy), 32'd0);
    start("b34", 8'h34);
    check("b34_done_clear", 32'(tx_done), 32'd0);
    run_frame(-1, 8'h00, -1, 8'h00, -1, bits, blen, lc, fh, gl);
    check("b34_bits", 32'(bits), 32'({1'b1, 8'h34, 1'b0}));
    check("b34_busy_len", 32'(blen), 32'd40);
    check("b34_done", 32'(tx_done), 32'd1);
    @(negedge clk);

    // Reset in mid-frame abandons the frame. The frame after it is clean.
    start("bc3", 8'hC3);
    run_frame(-1, 8'h00, -1, 8'h00, 17, bits, blen, lc, fh, gl);
    check("bc3_rst_len", 32'(blen), 32'd18);
    check("bc3_rst_txd", 32'(uart_txd), 32'd1);
    check("bc3_rst_busy", 32'(tx_busy), 32'd0);
    check("bc3_rst_done", 32'(tx_done), 32'd0);
    plain_frame("b81", 8'h81, lc, fh);
    @(negedge clk);

    // Changing tx_data after acceptance does not affect the frame.
    start("b0f", 8'h0F);
    run_frame(-1, 8'h00, 0, 8'hF0, -1, bits, blen, lc, fh, gl);
    check("b0f_bits", 32'(bits), 32'({1'b1, 8'h0F, 1'b0}));
    check("b0f_busy_len", 32'(blen), 32'd40);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
